// File: rtl/cpu_result_port.sv
// Result-bus pin port: live snapshot with lane select, or FIFO-backed beat
// serializer with valid/ready handshake and sticky overflow.
//
// state  | meaning
// S_IDLE | serializer empty, waiting for a FIFO entry
// S_SEND | presenting beats of the held word, LSB lane first
module cpu_result_port #(
   parameter int DATA_W = 32,
   parameter int LANE_W = 8,
   parameter int DEPTH  = 4,
   localparam int BEATS = DATA_W / LANE_W,
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BW-1:0]     lane_sel,
   output logic [LANE_W-1:0] lane_data,
   output logic [BW-1:0]     lane_idx,
   output logic              lane_valid,
   input  logic              lane_ready,
   output logic              lane_last,
   output logic [LW-1:0]     level,
   output logic              overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

   typedef enum logic {S_IDLE, S_SEND} ser_state_t;

   ser_state_t        state, state_nx;
   logic              mode_q;
   logic              flush, run, full, empty;
   logic              push, pop, drop, live_acc, beat_done;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] ser_word, snapshot;
   logic [DATA_W-1:0] ser_sh, snap_sh;
   logic [BW-1:0]     beat;
   logic              snap_valid;

   assign flush     = (mode != mode_q);
   assign run       = mode_q && !flush;
   assign full      = (level == FULL_LVL);
   assign empty     = (level == '0);
   assign in_ready  = !flush && (!mode_q || !full);
   assign push      = run && in_valid && !full;
   assign drop      = run && in_valid && full;
   assign live_acc  = !mode_q && !flush && in_valid;
   assign beat_done = (state == S_SEND) && lane_ready;
   assign ser_sh    = ser_word >> (int'(beat) * LANE_W);
   assign snap_sh   = snapshot >> (int'(lane_sel) * LANE_W);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      pop        = 1'b0;
      lane_valid = 1'b0;
      lane_data  = '0;
      lane_idx   = '0;
      lane_last  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (run && !empty) begin
               pop      = 1'b1;
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (beat_done && beat == LAST_BEAT) begin
               if (run && !empty) pop = 1'b1;
               else               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (flush) state_nx = S_IDLE;

      if (!mode_q) begin
         lane_valid = snap_valid;
         lane_data  = snap_sh[LANE_W-1:0];
         lane_idx   = lane_sel;
         lane_last  = (lane_sel == LAST_BEAT);
      end else if (state == S_SEND) begin
         lane_valid = 1'b1;
         lane_data  = ser_sh[LANE_W-1:0];
         lane_idx   = beat;
         lane_last  = (beat == LAST_BEAT);
      end
   end

   // mode is tracked through reset so leaving reset never looks like a flush
   always_ff @(posedge clk) mode_q <= mode;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         beat       <= '0;
         ser_word   <= '0;
         snapshot   <= '0;
         snap_valid <= 1'b0;
         overflow   <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         beat       <= '0;
         ser_word   <= '0;
         snap_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            ser_word <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
            beat     <= '0;
         end else if (beat_done) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
         end
         level <= level + LW'(push) - LW'(pop);
         if (drop) overflow <= 1'b1;
         if (live_acc) begin
            snapshot   <= in_data;
            snap_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_result_port.sv
// Bench for cpu_result_port: queue-level reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_cpu_result_port;
   localparam int DATA_W = 32;
   localparam int LANE_W = 8;
   localparam int DEPTH  = 4;
   localparam int BEATS  = DATA_W / LANE_W;
   localparam int BW     = 2;
   localparam int LW     = 3;

   logic              clk = 1'b0;
   logic              rst, mode, in_valid, lane_ready;
   logic [DATA_W-1:0] in_data;
   logic [BW-1:0]     lane_sel;
   logic              in_ready, lane_valid, lane_last, overflow;
   logic [LANE_W-1:0] lane_data;
   logic [BW-1:0]     lane_idx;
   logic [LW-1:0]     level;

   int checks = 0;
   int passes = 0;

   cpu_result_port #(.DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .lane_sel(lane_sel), .lane_data(lane_data),
      .lane_idx(lane_idx), .lane_valid(lane_valid), .lane_ready(lane_ready),
      .lane_last(lane_last), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // reference model: a word queue plus the word being sent
   logic [31:0] m_q[$];
   bit          m_busy = 0, m_snap_v = 0, m_ovf = 0, m_mq = 0;
   logic [31:0] m_word = 0, m_snap = 0;
   int          m_beat = 0;

   task automatic model_step();
      bit done, last, was_full;
      done = m_busy && lane_ready;
      last = 0;
      was_full = (m_q.size() == DEPTH);
      if (rst) begin
         m_q.delete(); m_busy = 0; m_beat = 0; m_snap = 0; m_snap_v = 0; m_ovf = 0;
      end else if (mode != m_mq) begin
         m_q.delete(); m_busy = 0; m_snap_v = 0; m_ovf = 0;
      end else if (m_mq) begin
         if (done) begin
            if (m_beat == BEATS - 1) last = 1;
            else m_beat++;
         end
         if ((!m_busy || last) && m_q.size() > 0) begin
            m_word = m_q.pop_front(); m_beat = 0; m_busy = 1;
         end else if (last) begin
            m_busy = 0;
         end
         if (in_valid) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(in_data);
         end
      end else if (in_valid) begin
         m_snap = in_data; m_snap_v = 1;
      end
      m_mq = mode;
   endtask

   task automatic compare();
      bit          e_rdy, e_v, e_last;
      logic [7:0]  e_d;
      int          e_idx;
      e_rdy = (mode != m_mq) ? 0 : (m_mq ? (m_q.size() < DEPTH) : 1);
      e_v = 0; e_d = 0; e_idx = 0; e_last = 0;
      if (!m_mq) begin
         e_v = m_snap_v; e_d = m_snap[int'(lane_sel)*8 +: 8];
         e_idx = int'(lane_sel); e_last = (lane_sel == 2'(BEATS - 1));
      end else if (m_busy) begin
         e_v = 1; e_d = m_word[m_beat*8 +: 8]; e_idx = m_beat; e_last = (m_beat == BEATS - 1);
      end
      chk("m_in_ready", 32'(in_ready), 32'(e_rdy));
      chk("m_lane_valid", 32'(lane_valid), 32'(e_v));
      chk("m_lane_data", 32'(lane_data), 32'(e_d));
      chk("m_lane_idx", 32'(lane_idx), e_idx);
      chk("m_lane_last", 32'(lane_last), 32'(e_last));
      chk("m_level", 32'(level), m_q.size());
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (!rst) compare();
   end

   logic [7:0]  got[$];
   logic [7:0]  exp_b[$];
   logic [31:0] words[$];

   initial begin
      logic [7:0]  t3 [8];
      logic [7:0]  t2 [4];
      logic [31:0] w;
      int          n, cyc;
      bit          stalled;
      logic [7:0]  prev_d;
      logic [BW-1:0] prev_i;

      rst = 1; mode = 1; in_valid = 0; in_data = 0; lane_sel = 0; lane_ready = 1;
      tick(); tick();
      rst = 0;
      #1;
      // 1: reset
      chk("rst_lane_valid", 32'(lane_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_lane_data", 32'(lane_data), 0);

      // 3: stream two words, full rate
      t3 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      tick();
      in_valid = 1; in_data = 32'h1122_3344;
      tick();
      in_data = 32'h5566_7788;
      #1 chk("lat_valid_e1", 32'(lane_valid), 0);
      tick();
      in_valid = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("s_valid", 32'(lane_valid), 1);
         chk("s_data", 32'(lane_data), 32'(t3[i]));
         chk("s_last", 32'(lane_last), (i % 4 == 3) ? 1 : 0);
         tick();
      end
      #1 chk("s_idle_after", 32'(lane_valid), 0);

      // 4: backpressure and overflow
      lane_ready = 0;
      for (int i = 0; i < 6; i++) begin
         words.push_back(32'hA0B0_C0D0 + 32'(i));
         in_valid = 1; in_data = words[i];
         tick();
      end
      in_valid = 0;
      #1;
      chk("bp_level", 32'(level), 4);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_overflow", 32'(overflow), 1);
      chk("bp_head", 32'(lane_data), 32'hD0);
      tick();
      lane_ready = 1;
      got.delete();
      for (cyc = 0; cyc < 40 && got.size() < 20; cyc++) begin
         #1;
         if (lane_valid && lane_ready) got.push_back(lane_data);
         tick();
      end
      chk("bp_beat_count", got.size(), 20);
      n = 0;
      for (int k = 0; k < 5; k++)
         for (int b = 0; b < 4; b++) begin
            w = words[k];
            if (n < got.size()) chk("bp_beat", 32'(got[n]), 32'(w[b*8 +: 8]));
            n++;
         end
      #1 chk("bp_drained", 32'(lane_valid), 0);

      // 5: mode-change flush with level 3
      lane_ready = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = 32'h0F0F_0000 + 32'(i);
         tick();
      end
      in_valid = 0;
      #1;
      chk("fl_level_pre", 32'(level), 3);
      chk("fl_ovf_pre", 32'(overflow), 1);
      tick();
      mode = 0;
      #1 chk("fl_in_ready", 32'(in_ready), 0);
      tick();
      #1;
      chk("fl_level", 32'(level), 0);
      chk("fl_overflow", 32'(overflow), 0);
      chk("fl_lane_valid", 32'(lane_valid), 0);
      chk("fl_in_ready_after", 32'(in_ready), 1);

      // 2: live mode
      t2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      tick();
      in_valid = 1; in_data = 32'hDEAD_BEEF;
      tick();
      in_valid = 0;
      for (int s = 0; s < 4; s++) begin
         lane_sel = 2'(s);
         #1;
         chk("lv_valid", 32'(lane_valid), 1);
         chk("lv_data", 32'(lane_data), 32'(t2[s]));
         chk("lv_last", 32'(lane_last), (s == 3) ? 1 : 0);
         chk("lv_level", 32'(level), 0);
         tick();
      end
      lane_sel = 0;

      // 6: random stalls over 20 words
      mode = 1;
      tick();
      words.delete(); exp_b.delete(); got.delete();
      for (int i = 0; i < 20; i++) begin
         w = $urandom();
         words.push_back(w);
         for (int b = 0; b < 4; b++) exp_b.push_back(w[b*8 +: 8]);
      end
      n = 0; stalled = 0; prev_d = 0; prev_i = 0;
      for (cyc = 0; cyc < 1000 && got.size() < 80; cyc++) begin
         lane_ready = 1'($urandom_range(0, 1));
         if (n < 20 && in_ready) begin
            in_valid = 1; in_data = words[n]; n++;
         end else begin
            in_valid = 0;
         end
         #1;
         if (stalled) begin
            chk("st_stable_data", 32'(lane_data), 32'(prev_d));
            chk("st_stable_idx", 32'(lane_idx), 32'(prev_i));
         end
         stalled = lane_valid && !lane_ready;
         prev_d = lane_data; prev_i = lane_idx;
         if (lane_valid && lane_ready) got.push_back(lane_data);
         tick();
      end
      in_valid = 0;
      chk("st_beat_count", got.size(), 80);
      for (int k = 0; k < 80 && k < got.size(); k++)
         chk("st_beat", 32'(got[k]), 32'(exp_b[k]));
      chk("st_overflow", 32'(overflow), 0);

      tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
